// File: rtl/pc_next_unit_if.sv
// Bundle between fetch control and the program-counter stage: redirect/control inputs
// plus the registered pc, link, flush and halted outputs.
interface pc_next_unit_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned IMM_W  = 16
);
  logic              branchf;
  logic [1:0]        br_kind;
  logic [IMM_W-1:0]  imm;
  logic [ADDR_W-1:0] reg_target;
  logic              ret;
  logic              stall;
  logic              halt;
  logic              resume;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] link;
  logic              flush;
  logic              halted;

  modport master (
    output branchf, br_kind, imm, reg_target, ret, stall, halt, resume,
    input  pc, link, flush, halted
  );

  modport slave (
    input  branchf, br_kind, imm, reg_target, ret, stall, halt, resume,
    output pc, link, flush, halted
  );
endinterface

// File: rtl/pc_next_unit.sv
// Program-counter stage: picks the next fetch address (increment, relative branch, call,
// return), flushes the wrong-path instruction after a redirect and supports halt/resume.
module pc_next_unit #(
  parameter int unsigned       ADDR_W       = 32,
  parameter int unsigned       IMM_W        = 16,
  parameter int unsigned       INSTR_BYTES  = 4,
  parameter logic [ADDR_W-1:0] RESET_PC     = '0,
  parameter int unsigned       FLUSH_CYCLES = 1
) (
  input logic           clk,
  input logic           reset,
  pc_next_unit_if.slave bus
);

  typedef enum logic [1:0] {StRun, StFlush, StHalted} state_e;

  localparam logic [2:0]        CntLoad = 3'(FLUSH_CYCLES - 1);
  localparam logic [ADDR_W-1:0] Incr    = ADDR_W'(INSTR_BYTES);

  state_e            state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] link_q, link_d;
  logic [ADDR_W-1:0] imm_sext, pc_seq, pc_rel;
  logic              is_call, is_rel;

  assign imm_sext = {{(ADDR_W - IMM_W){bus.imm[IMM_W-1]}}, bus.imm};
  assign pc_seq   = pc_q + Incr;
  assign pc_rel   = pc_q + imm_sext;
  assign is_call  = bus.branchf && (bus.br_kind == 2'b11);
  assign is_rel   = bus.branchf && (bus.br_kind == 2'b01 || bus.br_kind == 2'b10);

  // State register (pc, link and the flush counter move with the FSM).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StRun;
      cnt_q   <= '0;
      pc_q    <= RESET_PC;
      link_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pc_q    <= pc_d;
      link_q  <= link_d;
    end
  end

  // Next state. Priority: halt > stall > ret > branchf > increment.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pc_d    = pc_q;
    link_d  = link_q;
    unique case (state_q)
      StHalted: begin
        // halt wins over resume, so both high keeps us parked
        if (bus.resume && !bus.halt) begin
          state_d = StRun;
        end
      end
      StRun, StFlush: begin
        if (bus.halt) begin
          state_d = StHalted;
          cnt_d   = '0;
        end else if (!bus.stall) begin
          if (state_q == StFlush) begin
            // wrong-path slot: redirect requests are not trusted here
            pc_d = pc_seq;
            if (cnt_q == '0) begin
              state_d = StRun;
            end else begin
              cnt_d = cnt_q - 3'd1;
            end
          end else if (bus.ret) begin
            pc_d    = link_q;
            state_d = StFlush;
            cnt_d   = CntLoad;
          end else if (is_call) begin
            pc_d    = bus.reg_target;
            link_d  = pc_seq;
            state_d = StFlush;
            cnt_d   = CntLoad;
          end else if (is_rel) begin
            pc_d    = pc_rel;
            state_d = StFlush;
            cnt_d   = CntLoad;
          end else begin
            pc_d = pc_seq;
          end
        end
      end
      default: begin
        state_d = StRun;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs decode registered state only.
  always_comb begin
    bus.pc     = pc_q;
    bus.link   = link_q;
    bus.flush  = (state_q == StFlush);
    bus.halted = (state_q == StHalted);
  end

endmodule
